// File: rtl/burst_word_bridge.sv
// Burst-RAM responder that services each br_ burst as single-word accesses on a 1-cycle-latency memory port.
// Optional simulation-only protocol checks: define BURST_WORD_BRIDGE_PROTOCOL_CHECK_EN.
module burst_word_bridge #(
  parameter int DATA_BITWIDTH            = 64,
  parameter int DEPTH_BITWIDTH           = 8,
  parameter int BURST_COUNT              = 4,
  parameter int CYCLES_BEFORE_DATA_READY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd,
  input  logic                         cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]    addr,
  input  logic [DATA_BITWIDTH-1:0]     wr_data,
  input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
  output logic [DATA_BITWIDTH-1:0]     rd_data,
  output logic                         rd_data_valid,
  output logic                         busy,
  output logic                         mem_en,
  output logic [DATA_BITWIDTH/8-1:0]   mem_we,
  output logic [DEPTH_BITWIDTH-1:0]    mem_addr,
  output logic [DATA_BITWIDTH-1:0]     mem_din,
  input  logic [DATA_BITWIDTH-1:0]     mem_dout
);

  localparam int MASK_BITS = DATA_BITWIDTH / 8;
  localparam int CNT_BITS  = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam int WAIT_BITS = $clog2(CYCLES_BEFORE_DATA_READY + 1);
  localparam logic [CNT_BITS-1:0]  LAST_BEAT = CNT_BITS'(BURST_COUNT - 1);
  // READ_WAIT spans CYCLES_BEFORE_DATA_READY-2 cycles; it is skipped entirely when that is zero.
  localparam logic [WAIT_BITS-1:0] LAST_WAIT =
    WAIT_BITS'((CYCLES_BEFORE_DATA_READY > 2) ? CYCLES_BEFORE_DATA_READY - 3 : 0);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ_WAIT  = 3'd2,
    READ_ISSUE = 3'd3,
    READ_DRAIN = 3'd4
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [CNT_BITS-1:0]       beat_cnt;
  logic [WAIT_BITS-1:0]      wait_cnt;
  logic [DEPTH_BITWIDTH-1:0] base_addr;
  logic [DATA_BITWIDTH-1:0]  din_q;
  logic [MASK_BITS-1:0]      we_q;
  logic                      rd_valid_q;
  logic [DATA_BITWIDTH-1:0]  rd_hold;
  logic                      issuing;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_en) begin
          if (cmd)                                state_d = WRITE;
          else if (CYCLES_BEFORE_DATA_READY > 2)  state_d = READ_WAIT;
          else                                    state_d = READ_ISSUE;
        end
      end
      WRITE:      if (beat_cnt == LAST_BEAT) state_d = IDLE;
      READ_WAIT:  if (wait_cnt == LAST_WAIT) state_d = READ_ISSUE;
      READ_ISSUE: if (beat_cnt == LAST_BEAT) state_d = READ_DRAIN;
      READ_DRAIN: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  assign issuing = (state_q == WRITE) || (state_q == READ_ISSUE);

  // Write beats are captured every cycle; the state decides whether the captured beat reaches memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      base_addr  <= '0;
      din_q      <= '0;
      we_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_hold    <= '0;
    end else begin
      din_q <= wr_data;
      we_q  <= ~data_mask;
      if (state_q == IDLE && cmd_en) base_addr <= addr;
      beat_cnt   <= (issuing && state_d == state_q) ? beat_cnt + 1'b1 : '0;
      wait_cnt   <= (state_q == READ_WAIT) ? wait_cnt + 1'b1 : '0;
      rd_valid_q <= (state_q == READ_ISSUE);
      if (rd_valid_q) rd_hold <= mem_dout;
    end
  end

  always_comb begin
    busy          = (state_q != IDLE);
    mem_en        = issuing;
    mem_we        = (state_q == WRITE) ? we_q : '0;
    mem_din       = (state_q == WRITE) ? din_q : '0;
    mem_addr      = issuing ? base_addr + DEPTH_BITWIDTH'(beat_cnt) : '0;
    rd_data_valid = rd_valid_q;
    // Read beats pass straight from memory; the held copy covers cycles without a valid beat.
    rd_data       = rd_valid_q ? mem_dout : rd_hold;
  end

`ifdef BURST_WORD_BRIDGE_PROTOCOL_CHECK_EN
  logic chk_cmd_q;

  initial begin
    if (CYCLES_BEFORE_DATA_READY < 2)
      $display("ERROR %0t: burst_word_bridge CYCLES_BEFORE_DATA_READY=%0d is below 2",
               $time, CYCLES_BEFORE_DATA_READY);
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (cmd_en && state_q != IDLE)
        $display("ERROR %0t: burst_word_bridge cmd_en while busy", $time);
      if (state_q == WRITE && (cmd != chk_cmd_q || addr != base_addr))
        $display("ERROR %0t: burst_word_bridge cmd/addr changed during write burst", $time);
    end
    if (state_q == IDLE && cmd_en) chk_cmd_q <= cmd;
  end
`else
  // No protocol checks in this build.
`endif

endmodule

// File: tb/tb_burst_word_bridge.sv
// Self-checking bench for burst_word_bridge: directed plan plus random commands against a cycle-timeline model.
module tb_burst_word_bridge;
  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int MW    = 8;
  localparam int BC    = 4;
  localparam int CRD   = 3;
  localparam int NC    = 2048;
  localparam int S     = 300;
  localparam int RND0  = S + 80;
  localparam int ENDC  = NC - 16;

  // clock / reset / DUT
  logic clk = 1'b0;
  logic rst, cmd, cmd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] data_mask;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid, busy, mem_en;
  logic [MW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  burst_word_bridge #(
    .DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW), .BURST_COUNT(BC), .CYCLES_BEFORE_DATA_READY(CRD)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data),
    .data_mask(data_mask), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // synchronous block RAM with a preload port
  logic [DW-1:0] mem [256];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      for (int b = 0; b < MW; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      mem_dout <= mem[mem_addr];
    end
  end

  // stimulus plan and expected timeline
  logic          st_rst [NC];
  logic          st_en  [NC];
  logic          st_cmd [NC];
  logic [AW-1:0] st_addr[NC];
  logic [DW-1:0] st_wd  [NC];
  logic [MW-1:0] st_mask[NC];
  logic          e_busy [NC];
  logic          e_valid[NC];
  logic          e_men  [NC];
  logic [MW-1:0] e_mwe  [NC];
  logic [AW-1:0] e_maddr[NC];
  logic [DW-1:0] e_mdin [NC];
  logic [DW-1:0] e_rd   [NC];
  logic [DW-1:0] ref_mem[256];
  logic [DW-1:0] pre_val[256];
  logic [DW-1:0] exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h want %h", name, c, act, exp);
  endtask

  task automatic put(input int c, input logic w, input logic [AW-1:0] a);
    st_en[c]   = 1'b1;
    st_cmd[c]  = w;
    st_addr[c] = a;
  endtask

  task automatic build_plan();
    int r;
    for (int c = 0; c < NC; c++) begin
      st_rst[c]  = (c <= 260);
      st_en[c]   = 1'b0;
      st_cmd[c]  = 1'($urandom_range(0, 1));
      st_addr[c] = AW'($urandom);
      st_wd[c]   = {$urandom, $urandom};
      st_mask[c] = MW'($urandom);
    end
    for (int a = 0; a < 256; a++) pre_val[a] = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) pre_val[i] = 64'h1111_0000_0000_0000 | 64'(i);
    for (int i = 16; i < 20; i++) pre_val[i] = '1;

    put(S, 1'b0, 8'd4);
    put(S + 8, 1'b1, 8'd8);
    for (int i = 0; i < BC; i++) begin
      st_wd[S + 8 + i]   = 64'hA0 + 64'(i);
      st_mask[S + 8 + i] = '0;
    end
    put(S + 14, 1'b0, 8'd8);
    put(S + 22, 1'b1, 8'd16);
    st_wd[S + 22]   = '0;
    st_mask[S + 22] = 8'h0F;
    for (int i = 1; i < BC; i++) st_mask[S + 22 + i] = 8'hFF;
    put(S + 28, 1'b0, 8'd16);
    put(S + 36, 1'b0, 8'd254);
    put(S + 44, 1'b0, 8'd32);
    put(S + 46, 1'b1, 8'd0);
    for (int i = 0; i < BC; i++) st_mask[S + 46 + i] = '0;
    put(S + 54, 1'b0, 8'd0);
    put(S + 62, 1'b0, 8'd4);
    st_rst[S + 64] = 1'b1;
    put(S + 68, 1'b0, 8'd4);

    for (int c = RND0; c < ENDC - BC - CRD - 4; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        st_en[c] = 1'b1;
        if ($urandom_range(0, 3) == 0) st_addr[c] = AW'($urandom_range(250, 255));
      end
      r = $urandom_range(0, 3);
      if (r == 0) st_mask[c] = '0;
      else if (r == 1) st_mask[c] = '1;
    end
  endtask

  // Model: a command is taken only once the previous burst's busy window has ended.
  task automatic run_model();
    int busy_end;
    logic [AW-1:0] a;
    logic [DW-1:0] hold;
    for (int a2 = 0; a2 < 256; a2++) ref_mem[a2] = pre_val[a2];
    for (int c = 0; c < NC; c++) begin
      e_busy[c] = 0; e_valid[c] = 0; e_men[c] = 0; e_mwe[c] = '0;
      e_maddr[c] = '0; e_mdin[c] = '0; e_rd[c] = '0;
    end
    busy_end = -1;
    for (int n = 0; n < ENDC; n++) begin
      if (st_rst[n]) begin
        for (int c = n + 1; c < NC && c <= n + CRD + BC + 1; c++) begin
          e_busy[c] = 0; e_valid[c] = 0; e_men[c] = 0; e_mwe[c] = '0;
        end
        busy_end = n;
      end else if (st_en[n] && n > busy_end) begin
        if (st_cmd[n]) begin
          for (int i = 0; i < BC; i++) begin
            a = st_addr[n] + AW'(i);
            e_men[n + 1 + i]   = 1'b1;
            e_mwe[n + 1 + i]   = ~st_mask[n + i];
            e_maddr[n + 1 + i] = a;
            e_mdin[n + 1 + i]  = st_wd[n + i];
            for (int b = 0; b < MW; b++)
              if (!st_mask[n + i][b]) ref_mem[a][b*8 +: 8] = st_wd[n + i][b*8 +: 8];
          end
          busy_end = n + BC;
        end else begin
          for (int i = 0; i < BC; i++) begin
            a = st_addr[n] + AW'(i);
            e_men[n + CRD - 1 + i]   = 1'b1;
            e_maddr[n + CRD - 1 + i] = a;
            e_valid[n + CRD + i]     = 1'b1;
            e_rd[n + CRD + i]        = ref_mem[a];
          end
          busy_end = n + CRD + BC - 1;
        end
        for (int c = n + 1; c <= busy_end; c++) e_busy[c] = 1'b1;
      end
    end
    hold = '0;
    for (int c = 0; c < NC; c++) begin
      if (c > 0 && st_rst[c - 1]) hold = '0;
      if (e_valid[c]) begin
        hold = e_rd[c];
        exp_q.push_back(e_rd[c]);
      end else e_rd[c] = hold;
    end
  endtask

  task automatic drive(input int n);
    rst       = st_rst[n];
    cmd_en    = st_en[n];
    cmd       = st_cmd[n];
    addr      = st_addr[n];
    wr_data   = st_wd[n];
    data_mask = st_mask[n];
    pre_en    = (n >= 1 && n <= 256);
    pre_addr  = AW'(n - 1);
    pre_data  = pre_val[AW'(n - 1)];
  endtask

  task automatic check_cycle(input int n);
    logic [DW-1:0] q;
    chk("busy",          n, 64'(busy),          64'(e_busy[n]));
    chk("rd_data_valid", n, 64'(rd_data_valid), 64'(e_valid[n]));
    chk("rd_data",       n, rd_data,            e_rd[n]);
    chk("mem_en",        n, 64'(mem_en),        64'(e_men[n]));
    chk("mem_we",        n, 64'(mem_we),        64'(e_mwe[n]));
    if (e_men[n]) chk("mem_addr", n, 64'(mem_addr), 64'(e_maddr[n]));
    if (e_mwe[n] != '0) chk("mem_din", n, mem_din, e_mdin[n]);
    if (rd_data_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_beat_unexpected", n, rd_data, ~rd_data);
      else begin
        q = exp_q.pop_front();
        chk("rd_beat_order", n, rd_data, q);
      end
    end
  endtask

  initial begin
    build_plan();
    run_model();

    // hand-computed pins on the model
    chk("pin_preload_beat0",  S + 3,  e_rd[S + 3],  64'h1111_0000_0000_0004);
    chk("pin_preload_beat3",  S + 6,  e_rd[S + 6],  64'h1111_0000_0000_0007);
    chk("pin_busy_last",      S + 6,  64'(e_busy[S + 6]), 64'd1);
    chk("pin_busy_drop",      S + 7,  64'(e_busy[S + 7]), 64'd0);
    chk("pin_we_first",       S + 9,  64'(e_mwe[S + 9]),  64'hFF);
    chk("pin_we_last",        S + 12, 64'(e_mwe[S + 12]), 64'hFF);
    chk("pin_we_after",       S + 13, 64'(e_mwe[S + 13]), 64'h00);
    chk("pin_readback_a0",    S + 17, e_rd[S + 17], 64'hA0);
    chk("pin_readback_a3",    S + 20, e_rd[S + 20], 64'hA3);
    chk("pin_byte_mask",      S + 31, e_rd[S + 31], 64'h0000_0000_FFFF_FFFF);
    chk("pin_masked_word17",  S + 32, e_rd[S + 32], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_wrap_addr",      S + 40, 64'(e_maddr[S + 40]), 64'd0);
    chk("pin_wrap_data",      S + 41, e_rd[S + 41], 64'h1111_0000_0000_0000);
    chk("pin_collision_word0", S + 57, e_rd[S + 57], 64'h1111_0000_0000_0000);
    chk("pin_reset_no_valid", S + 65, 64'(e_valid[S + 65]), 64'd0);
    chk("pin_after_reset",    S + 71, e_rd[S + 71], 64'h1111_0000_0000_0004);

    fork
      begin
        drive(0);
        for (int n = 1; n < ENDC; n++) begin
          @(posedge clk);
          #1;
          drive(n);
        end
      end
      begin
        for (int n = 1; n < ENDC; n++) begin
          @(negedge clk);
          check_cycle(n);
        end
      end
    join

    chk("rd_queue_empty", ENDC, 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/burst_word_bridge.md
Name: burst_word_bridge

Overview:
- Responder end of the `br_` burst-RAM command interface: it presents the same cmd/addr/wr_data/rd_data/busy signalling the cache controller drives.
- Each burst is serviced by sequencing single 64-bit word accesses on a plain synchronous-memory port (BRAM/SRAM, 1-cycle read latency).
- Lets the cache run against on-chip block RAM without the external burst RAM. Read latency is programmable so cache timing matches the burst-RAM configuration.

Parameters:
- DATA_BITWIDTH, 64, width of one burst beat and one memory word.
- DEPTH_BITWIDTH, 8, word-address width; memory holds 2^DEPTH_BITWIDTH words.
- BURST_COUNT, 4, beats per command.
- CYCLES_BEFORE_DATA_READY, 3, cycles from the read cmd_en cycle to the first rd_data_valid. Must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd  in  1  0 = read burst, 1 = write burst; sampled with cmd_en
- cmd_en  in  1  command strobe, one cycle
- addr  in  DEPTH_BITWIDTH  first word address of the burst
- wr_data  in  DATA_BITWIDTH  write beat; beat 0 arrives with cmd_en, beats 1..BURST_COUNT-1 on the following consecutive cycles
- data_mask  in  DATA_BITWIDTH/8  per-byte mask for the current write beat; bit=1 means that byte is NOT written
- rd_data  out  DATA_BITWIDTH  read beat
- rd_data_valid  out  1  rd_data holds a valid beat this cycle
- busy  out  1  command in progress; new cmd_en is not accepted
- mem_en  out  1  memory access strobe
- mem_we  out  DATA_BITWIDTH/8  byte write enables, active high
- mem_addr  out  DEPTH_BITWIDTH  memory word address
- mem_din  out  DATA_BITWIDTH  memory write data
- mem_dout  in  DATA_BITWIDTH  memory read data, valid the cycle after a read strobe

Behaviour:
- **Reset.** Synchronous on rising clk with rst=1. All outputs are 0 and the FSM is in IDLE. rst overrides any state mid-burst: a partial write stays partially committed, and pending read beats are dropped (no rd_data_valid after reset).
- **States.** IDLE, WRITE, READ_WAIT, READ_ISSUE, READ_DRAIN. A beat counter has clog2(BURST_COUNT) bits.
- **Burst addressing.** Beat i targets word (addr + i) mod 2^DEPTH_BITWIDTH; the address wraps at the top of memory.
- **IDLE.** busy=0. A cmd_en at cycle T latches cmd and addr. The FSM goes to WRITE if cmd=1, otherwise to READ_WAIT. cmd_en is ignored in every other state.
- **Write burst.**
  - Beat i is registered at cycle T+i and written to memory at cycle T+1+i: mem_en=1, mem_we=~data_mask, mem_din=beat, mem_addr=addr+i.
  - busy=1 over cycles T+1..T+BURST_COUNT.
  - Back to IDLE; the next cmd_en is accepted at T+BURST_COUNT+1.
- **Read burst.**
  - READ_WAIT idles until cycle T+CYCLES_BEFORE_DATA_READY-1.
  - READ_ISSUE then issues BURST_COUNT consecutive reads: mem_en=1, mem_we=0.
  - mem_dout is forwarded so that rd_data_valid=1 on cycles T+CYCLES_BEFORE_DATA_READY .. T+CYCLES_BEFORE_DATA_READY+BURST_COUNT-1, with beats in address order and no gaps.
  - busy=1 from T+1 through the last valid beat. The next cmd_en is accepted on the following cycle.
- **Read output hold.** rd_data holds the last beat once rd_data_valid drops.
- **Idle memory port.** Outside accesses, mem_en=0 and mem_we=0.
- **cmd_en while busy.** Silently dropped; no effect on the current burst.

Optional Feature:
- Macro: BURST_WORD_BRIDGE_PROTOCOL_CHECK_EN.
- Defined:
  - simulation-only checks that $display an error with the time on: cmd_en while busy; cmd or addr changing during a write burst; CYCLES_BEFORE_DATA_READY < 2 at elaboration.
  - The RTL's functional behaviour is unchanged.
- Undefined: no checks compiled in; behaviour identical.

Test Plan:
- **Read burst from preload.** Preload words 0..7 with 0x1111_0000_0000_000i; cmd_en read at addr=4 at cycle T → rd_data_valid on T+3..T+6 with 0x...0004..0x...0007, then busy=0 at T+7.
- **Write then read back.** Write burst at addr=8 with beats 0xA0..0xA3 and data_mask=0 → read at addr=8 returns 0xA0,0xA1,0xA2,0xA3. mem_we=0xFF on exactly 4 cycles, T+1..T+4.
- **Byte mask.** Word 16 preloaded 0xFFFF_FFFF_FFFF_FFFF; write beat 0 = 0 with data_mask=0x0F (beats 1-3 fully masked) → word 16 reads 0x0000_0000_FFFF_FFFF; words 17-19 are unchanged.
- **Address wrap.** Read at addr=254 → beats come from words 254, 255, 0, 1.
- **Busy collision.** cmd_en write at addr=0 issued at T+2 during a read burst → ignored: word 0 is unchanged and read beats are unaffected. Also checks the macro message when it is defined.
- **Reset mid-read.** rst=1 at T+2 of a read → no rd_data_valid afterwards, all outputs 0. A read issued after rst deasserts returns correct data.
